keypad_code_entry: RTL
======================

# keypad_code_entry

Front-end code-entry stage for the digital lock. Converts four raw, bouncy pushbuttons (bit-0, bit-1, enter, clear) into a 4-bit `password` and a level `open` request, which feed the lock FSM's `password`/`open` inputs directly. The block covers synchronisation, debouncing, serial bit assembly, entry validation and idle timeout.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised input must differ from its debounced level before that level flips. Legal range is 2 or more.
- `TIMEOUT_CYCLES`, default 1000: idle cycles after the last accepted bit press before a partial entry is discarded. Legal range is 2 or more.
- `clk`, in, 1: clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `btn0_raw`, in, 1: raw button that enters a 0 bit; asynchronous to `clk`.
- `btn1_raw`, in, 1: raw button that enters a 1 bit; asynchronous to `clk`.
- `btn_enter_raw`, in, 1: raw enter button; asynchronous to `clk`.
- `btn_clear_raw`, in, 1: raw clear button; asynchronous to `clk`.
- `password`, out, 4: latched code. Valid while `open`=1, otherwise 4'b0000.
- `open`, out, 1: request to unlock. Level output, held while enter is held.
- `digit_count`, out, 3: number of bits entered so far, 0..4.
- `entry_error`, out, 1: one-cycle pulse on a rejected action.

## Operation
- **Input conditioning (per button):**
  - Each raw input passes through a 2-flop synchroniser.
  - A debouncer holds a `stable` level (reset 0) and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever sync equals `stable`. Otherwise it increments; when it reaches DEBOUNCE_CYCLES, `stable` flips and the counter clears.
  - A press event is a one-cycle pulse: `stable` high and previous `stable` low.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- **Shift register:** 4 bits, shifted left. The first entered bit ends up as `password[3]`.
- **States:**
  - ENTRY (reset state): bit0 or bit1 event shifts the bit in and increments `digit_count`. When the count becomes 4, go to READY.
  - READY: bit events are ignored and pulse `entry_error`. An enter event latches the shift register into `password`, sets `open`=1 and goes to OPEN.
  - OPEN: `open`=1 while debounced enter is high. When debounced enter goes low: `open`=0, `password`=0, shift register=0, count=0, go to ENTRY. Bit events are ignored silently.
- **Enter event in ENTRY (count < 4):** pulse `entry_error`, clear the shift register and count, stay in ENTRY.
- **Event priority, highest first:**
  - Clear event, from any state: go to ENTRY, clear all, `open`=0, no error pulse.
  - Enter event.
  - Bit events.
- **Simultaneous bit0 and bit1 events:** both are ignored and `entry_error` pulses; in ENTRY the count is unchanged.
- **Idle timeout:**
  - An idle counter runs in ENTRY with count > 0, and in READY.
  - It clears on every accepted bit event and holds 0 otherwise.
  - On reaching TIMEOUT_CYCLES it clears the shift register and count, returns to ENTRY and pulses `entry_error`.
  - If a timeout and an event land in the same cycle, the event wins.
- **Asynchronous reset, including mid-entry or mid-OPEN:** every flop goes to 0 and the FSM goes to ENTRY.
  - A button held through reset release produces one press event after debounce.

## Timing
- Reset values: `password`=0, `open`=0, `digit_count`=0, `entry_error`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: a raw level change first sampled at edge N is reflected in the outputs after edge N+2+DEBOUNCE_CYCLES.
  - This covers the 2-flop sync, the debounce count, and the event-to-FSM register stage.
- `open` and `password` change on the same edge. `password` is stable for the whole time `open` is high.
- `entry_error` is high for exactly one cycle per rejected action.
- A timeout fires on the edge at which the idle count reaches TIMEOUT_CYCLES.
- Release of enter drops `open` after the same N+2+DEBOUNCE_CYCLES latency.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=64.
- **Correct code:** press 0,1,0,1, then hold enter → `digit_count` goes 1,2,3,4. `open`=1 with `password`=4'b0101 at edge N+6 after enter is sampled. Releasing enter → `open`=0, `password`=0, `digit_count`=0.
- **Bounce:** each raw press toggles for 3 cycles before settling → exactly one bit accepted per press. A 3-cycle isolated glitch → no change.
- **Short entry:** press 1,1, then enter → one-cycle `entry_error`, `digit_count`=0, `open` stays 0.
- **Extra bit, then clear:** enter 4 bits then press btn1 → `entry_error` pulse, code unchanged. A later clear → `digit_count`=0, no error pulse.
- **Timeout:** press 1, then idle 64 cycles → `digit_count` returns to 0 and `entry_error` pulses once. Pressing a bit at idle count 63 → the count is restarted instead of timing out.
- **Reset mid-operation:** assert `reset_n`=0 while in OPEN with `password`=4'b1010 → `open`, `password` and `digit_count` go to 0 immediately. With enter held through release → no `open` until a fresh 4-bit entry is made.

Source files
------------

// File: rtl/keypad_code_entry_if.sv
// keypad_code_entry_if
//   Groups the keypad front-end signals: four raw pushbuttons towards the
//   code-entry block and the conditioned code/request outputs back out.
//   master : drives the raw buttons, observes the outputs (keypad / bench side)
//   slave  : receives the raw buttons, drives the outputs (keypad_code_entry)
//   Signals:
//     btn0_raw, btn1_raw, btn_enter_raw, btn_clear_raw : raw async buttons
//     password[3:0] : latched code, valid while open=1, else 0
//     open          : unlock request level, held while enter is held
//     digit_count   : bits entered so far, 0..4
//     entry_error   : one-cycle pulse on a rejected action
interface keypad_code_entry_if;
  logic       btn0_raw;
  logic       btn1_raw;
  logic       btn_enter_raw;
  logic       btn_clear_raw;
  logic [3:0] password;
  logic       open;
  logic [2:0] digit_count;
  logic       entry_error;

  modport master (
    output btn0_raw, btn1_raw, btn_enter_raw, btn_clear_raw,
    input  password, open, digit_count, entry_error
  );

  modport slave (
    input  btn0_raw, btn1_raw, btn_enter_raw, btn_clear_raw,
    output password, open, digit_count, entry_error
  );
endinterface

// File: rtl/keypad_code_entry.sv
// keypad_code_entry
//   Front-end code-entry stage for the digital lock. Synchronises and
//   debounces four raw pushbuttons, assembles a 4-bit code serially (first
//   bit ends up in password[3]), validates the entry and raises a level
//   'open' request while enter is held. A partial entry is discarded after
//   TIMEOUT_CYCLES idle cycles.
//   Parameters:
//     DEBOUNCE_CYCLES : cycles a synchronised input must differ from its
//                       debounced level before the level flips (>= 2)
//     TIMEOUT_CYCLES  : idle cycles after the last accepted bit before a
//                       partial entry is dropped (>= 2)
//   Ports:
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset
//     kp      : keypad_code_entry_if.slave (raw buttons in, code/status out)
module keypad_code_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  keypad_code_entry_if.slave   kp
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

  // Button index map: 0 = bit0, 1 = bit1, 2 = enter, 3 = clear
  localparam int unsigned B_ZERO  = 0;
  localparam int unsigned B_ONE   = 1;
  localparam int unsigned B_ENTER = 2;
  localparam int unsigned B_CLEAR = 3;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    READY = 2'd1,
    OPEN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    stable;
  logic [3:0]    stable_q;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    press;

  assign raw = {kp.btn_clear_raw, kp.btn_enter_raw, kp.btn1_raw, kp.btn0_raw};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          // This increment would reach DEBOUNCE_CYCLES: flip instead.
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle press events, consumed by the FSM register stage below.
  assign press = stable & ~stable_q;

  logic ev_zero;
  logic ev_one;
  logic ev_enter;
  logic ev_clear;
  logic ev_any;
  logic enter_level;

  assign ev_zero     = press[B_ZERO];
  assign ev_one      = press[B_ONE];
  assign ev_enter    = press[B_ENTER];
  assign ev_clear    = press[B_CLEAR];
  assign ev_any      = |press;
  assign enter_level = stable[B_ENTER];

  // ---------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [3:0]    shift_q;
  logic [3:0]    shift_next;
  logic [2:0]    count_q;
  logic [2:0]    count_next;
  logic [3:0]    pw_q;
  logic [3:0]    pw_next;
  logic          open_q;
  logic          open_next;
  logic          err_q;
  logic          err_next;
  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_next;
  logic          accept;
  logic          running;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ENTRY;
      shift_q <= '0;
      count_q <= '0;
      pw_q    <= '0;
      open_q  <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      count_q <= count_next;
      pw_q    <= pw_next;
      open_q  <= open_next;
      err_q   <= err_next;
      idle_q  <= idle_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_next = shift_q;
    count_next = count_q;
    pw_next    = pw_q;
    open_next  = open_q;
    err_next   = 1'b0;
    idle_next  = '0;
    accept     = 1'b0;
    running    = ((state == ENTRY) && (count_q != 3'd0)) || (state == READY);

    if (ev_clear) begin
      state_next = ENTRY;
      shift_next = '0;
      count_next = '0;
      pw_next    = '0;
      open_next  = 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (ev_enter) begin
            err_next   = 1'b1;
            shift_next = '0;
            count_next = '0;
          end else if (ev_zero && ev_one) begin
            err_next = 1'b1;
          end else if (ev_zero || ev_one) begin
            shift_next = {shift_q[2:0], ev_one};
            count_next = count_q + 3'd1;
            accept     = 1'b1;
            if (count_q == 3'd3) begin
              state_next = READY;
            end
          end
        end
        READY: begin
          if (ev_enter) begin
            pw_next    = shift_q;
            open_next  = 1'b1;
            state_next = OPEN;
          end else if (ev_zero || ev_one) begin
            err_next = 1'b1;
          end
        end
        OPEN: begin
          // Bit events are dropped silently here; only enter release matters.
          if (!enter_level) begin
            state_next = ENTRY;
            shift_next = '0;
            count_next = '0;
            pw_next    = '0;
            open_next  = 1'b0;
          end
        end
        default: begin
          state_next = ENTRY;
        end
      endcase

      // Idle timeout. An event in the expiry cycle wins; the counter then
      // parks at its last value so expiry happens on the next quiet cycle.
      if (running && !accept) begin
        if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
          if (!ev_any) begin
            state_next = ENTRY;
            shift_next = '0;
            count_next = '0;
            err_next   = 1'b1;
          end else begin
            idle_next = idle_q;
          end
        end else begin
          idle_next = idle_q + 1'b1;
        end
      end
    end

    if ((state_next == OPEN) || ((state_next == ENTRY) && (count_next == 3'd0))) begin
      idle_next = '0;
    end
  end

  assign kp.password    = pw_q;
  assign kp.open        = open_q;
  assign kp.digit_count = count_q;
  assign kp.entry_error = err_q;

endmodule
